// File: rtl/matrix_transpose_loader_pkg.sv
// Shared types and helpers for the B-matrix transpose loader and the
// multiplier sequencer that reuses its index counter.
package matrix_transpose_loader_pkg;

  localparam int unsigned FLOAT_W = 32;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Flat slot of element B[r][c] inside B_T (B_T is N rows of M words).
  function automatic int unsigned tidx(input int unsigned r,
                                       input int unsigned c,
                                       input int unsigned m);
    return c * m + r;
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major r/c wrap counter with synchronous clear and a last-position flag.
module matrix_index_counter #(
  parameter  int unsigned ROWS = 2,
  parameter  int unsigned COLS = 2,
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last_c
);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  // Clear wins over advance; column wraps into the row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (r_col == CW'(COLS - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row    = r_row;
  assign o_col    = r_col;
  assign o_last_c = (r_row == RW'(ROWS - 1)) && (r_col == CW'(COLS - 1));

endmodule

// File: rtl/matrix_transpose_loader.sv
// Accepts B row-major on a valid/ready stream and presents it transposed as a
// flat B_T bus, held stable until the downstream multiplier takes it.
module matrix_transpose_loader
  import matrix_transpose_loader_pkg::*;
#(
  parameter int unsigned M = 2,
  parameter int unsigned N = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [FLOAT_W-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  output logic [FLOAT_W*M*N-1:0]   B_T,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     err
);

  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic                     r_err;
  logic                     w_err_nxt;
  logic [FLOAT_W*M*N-1:0]   r_bt;
  logic                     w_we;
  logic                     w_clear;
  logic                     w_advance;
  logic [RW-1:0]            w_row;
  logic [CW-1:0]            w_col;
  logic                     w_last;
  logic [31:0]              w_slot;

  matrix_index_counter #(
    .ROWS (M),
    .COLS (N)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last_c  (w_last)
  );

  assign w_slot = tidx(32'(w_row), 32'(w_col), M);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Early in_last drops the element and restarts; a final element without
  // in_last still completes the matrix but is flagged.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      ST_LOAD: begin
        if (in_valid) begin
          if (in_last && !w_last) begin
            w_clear   = 1'b1;
            w_err_nxt = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_advance = 1'b1;
            if (w_last) begin
              w_state_nxt = ST_FULL;
              w_err_nxt   = !in_last;
            end
          end
        end
      end
      ST_FULL: begin
        if (out_ready) begin
          w_state_nxt = ST_LOAD;
        end
      end
    endcase
  end

  // Scatter each accepted word straight into its transposed slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bt <= '0;
    end else begin
      for (int unsigned i = 0; i < M * N; i++) begin
        if (w_we && (w_slot == i)) begin
          r_bt[i*FLOAT_W +: FLOAT_W] <= in_data;
        end
      end
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_state == ST_FULL);
  assign err       = r_err;
  assign B_T       = r_bt;

endmodule
